// File: rtl/inst_mem_ctrl_pkg.sv
// Shared types and constants for the instruction-memory sequencer.
package inst_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_RESP = 2'd3
    } state_e;

    typedef enum logic {
        GNT_FETCH = 1'b0,
        GNT_LOAD  = 1'b1
    } grant_e;

    localparam int unsigned BYTES_PER_INST = 4;
    localparam logic [31:0] NOP_INST       = 32'h0000_0000;

    // Highest byte address at which a whole instruction still fits. Done in
    // 33 bits so an address close to 2^32 cannot wrap back into range.
    function automatic logic [32:0] last_fetch_start(input int unsigned mem_size);
        return 33'(mem_size) - 33'(BYTES_PER_INST);
    endfunction

endpackage

// File: rtl/inst_mem_ctrl_if.sv
// Fetch port, loader port and byte-memory port of the instruction-memory sequencer.
interface inst_mem_ctrl_if;

    logic        fetch_req;
    logic [31:0] fetch_pc;
    logic        fetch_ack;
    logic [31:0] fetch_inst;
    logic        fetch_err;

    logic        ld_valid;
    logic [31:0] ld_addr;
    logic [7:0]  ld_data;
    logic        ld_ready;

    logic [31:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;

    logic        busy;

    modport slave (
        input  fetch_req, fetch_pc, ld_valid, ld_addr, ld_data, mem_rdata,
        output fetch_ack, fetch_inst, fetch_err, ld_ready,
               mem_addr, mem_we, mem_wdata, busy
    );

    modport master (
        output fetch_req, fetch_pc, ld_valid, ld_addr, ld_data, mem_rdata,
        input  fetch_ack, fetch_inst, fetch_err, ld_ready,
               mem_addr, mem_we, mem_wdata, busy
    );

endinterface

// File: rtl/inst_mem_ctrl_rr_arb2.sv
// Two-way round-robin arbiter between instruction fetch and program loader.
// The grant is only valid while enabled; last_grant moves only on an acceptance.
module inst_mem_rr_arb2
    import inst_mem_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   en,
    input  logic   req_fetch,
    input  logic   req_load,
    output logic   gnt_valid,
    output grant_e gnt
);

    grant_e last_grant_q;
    grant_e last_grant_d;

    // Pick a winner; on contention the side that did not win last time goes.
    always_comb begin
        gnt          = GNT_FETCH;
        gnt_valid    = en & (req_fetch | req_load);
        last_grant_d = last_grant_q;
        if (req_fetch && req_load) begin
            if (last_grant_q == GNT_LOAD) begin
                gnt = GNT_FETCH;
            end else begin
                gnt = GNT_LOAD;
            end
        end else if (req_load) begin
            gnt = GNT_LOAD;
        end
        if (gnt_valid) begin
            last_grant_d = gnt;
        end
    end

    // History register; starts as if the loader had won last.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= GNT_LOAD;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/inst_mem_ctrl.sv
// Sequencer for the single-port byte-wide instruction memory. Serialises a
// 32-bit big-endian fetch into four byte reads and interleaves loader writes.
//
//  state   | meaning
//  --------+-------------------------------------------------------------
//  ST_IDLE | arbitrate; accept one fetch or one loader byte
//  ST_RD   | reading byte cnt (0..3) of the fetch at pc_q + cnt
//  ST_WR   | loader byte being written (mem_we high if address valid)
//  ST_RESP | fetch_ack pulse with fetch_inst / fetch_err
module inst_mem_ctrl
    import inst_mem_pkg::*;
#(
    parameter int unsigned MEM_SIZE = 511,
    parameter logic [31:0] NOP_INST = inst_mem_pkg::NOP_INST
) (
    input  logic            clk,
    input  logic            rst_n,
    inst_mem_ctrl_if.slave  bus
);

    state_e      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] pc_q, pc_d;
    logic        err_q, err_d;
    logic [23:0] asm_q, asm_d;
    logic [31:0] fetch_inst_q, fetch_inst_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic        mem_we_q, mem_we_d;
    logic [7:0]  mem_wdata_q, mem_wdata_d;

    logic        gnt_valid;
    grant_e      gnt;
    logic        fetch_in_range;
    logic        ld_in_range;

    inst_mem_rr_arb2 u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (state_q == ST_IDLE),
        .req_fetch (bus.fetch_req),
        .req_load  (bus.ld_valid),
        .gnt_valid (gnt_valid),
        .gnt       (gnt)
    );

    assign fetch_in_range = ({1'b0, bus.fetch_pc} <= last_fetch_start(MEM_SIZE));
    assign ld_in_range    = ({1'b0, bus.ld_addr} < 33'(MEM_SIZE));

    assign bus.fetch_ack  = (state_q == ST_RESP);
    assign bus.fetch_err  = (state_q == ST_RESP) & err_q;
    assign bus.fetch_inst = fetch_inst_q;
    assign bus.ld_ready   = gnt_valid & (gnt == GNT_LOAD);
    assign bus.busy       = (state_q != ST_IDLE);
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_wdata  = mem_wdata_q;

    // Next-state, address sequencing and byte-lane assembly.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        pc_d         = pc_q;
        err_d        = err_q;
        asm_d        = asm_q;
        fetch_inst_d = fetch_inst_q;
        mem_addr_d   = mem_addr_q;
        mem_we_d     = 1'b0;
        mem_wdata_d  = mem_wdata_q;

        case (state_q)
            ST_IDLE: begin
                if (gnt_valid) begin
                    if (gnt == GNT_FETCH) begin
                        pc_d  = bus.fetch_pc;
                        cnt_d = 2'd0;
                        if (fetch_in_range) begin
                            err_d      = 1'b0;
                            mem_addr_d = bus.fetch_pc;
                            state_d    = ST_RD;
                        end else begin
                            // Rejected fetch never touches the memory port.
                            err_d        = 1'b1;
                            fetch_inst_d = NOP_INST;
                            state_d      = ST_RESP;
                        end
                    end else begin
                        // Out-of-range loader bytes are accepted but not written.
                        mem_addr_d  = bus.ld_addr;
                        mem_wdata_d = bus.ld_data;
                        mem_we_d    = ld_in_range;
                        state_d     = ST_WR;
                    end
                end
            end

            ST_RD: begin
                case (cnt_q)
                    2'd0:    asm_d[23:16] = bus.mem_rdata;
                    2'd1:    asm_d[15:8]  = bus.mem_rdata;
                    2'd2:    asm_d[7:0]   = bus.mem_rdata;
                    default: fetch_inst_d = {asm_q, bus.mem_rdata};
                endcase
                if (cnt_q == 2'd3) begin
                    state_d = ST_RESP;
                end else begin
                    cnt_d      = 2'(cnt_q + 2'd1);
                    mem_addr_d = pc_q + 32'(cnt_q) + 32'd1;
                end
            end

            ST_WR:   state_d = ST_IDLE;
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 2'd0;
            pc_q         <= 32'd0;
            err_q        <= 1'b0;
            asm_q        <= 24'd0;
            fetch_inst_q <= NOP_INST;
            mem_addr_q   <= 32'd0;
            mem_we_q     <= 1'b0;
            mem_wdata_q  <= 8'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            pc_q         <= pc_d;
            err_q        <= err_d;
            asm_q        <= asm_d;
            fetch_inst_q <= fetch_inst_d;
            mem_addr_q   <= mem_addr_d;
            mem_we_q     <= mem_we_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

endmodule
